// File: rtl/mult16_seq.sv
// Sequential unsigned 16x16 shift-and-add multiplier driving one CLA16bit adder
// per iteration; a 32-bit product is ready 17 cycles after start is accepted.

module CLA16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:1]  gc;

  assign g = A & B;
  assign p = A ^ B;

  // Two-level lookahead: 4-bit groups, then a lookahead unit across groups.
  for (genvar k = 0; k < 4; k++) begin : g_grp
    localparam int B0 = 4 * k;
    logic cin_grp;

    assign cin_grp = (k == 0) ? Cin : gc[k];
    assign gp[k] = &p[B0 +: 4];
    assign gg[k] = g[B0+3] | (p[B0+3] & g[B0+2]) | (p[B0+3] & p[B0+2] & g[B0+1])
                 | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);

    assign c[B0]   = cin_grp;
    assign c[B0+1] = g[B0] | (p[B0] & cin_grp);
    assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & cin_grp);
    assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                   | (p[B0+2] & p[B0+1] & p[B0] & cin_grp);
  end

  assign gc[1] = gg[0] | (gp[0] & Cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & Cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);

  assign Sum  = p ^ c;
  assign Cout = gc[4];
endmodule

module mult16_seq #(
  parameter int WIDTH = 16  // the adder instance is 16 bits wide; no other value works
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   acc;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod_r;

  logic [WIDTH-1:0]   add_b, sum;
  logic               cout;
  logic [2*WIDTH:0]   acc_shifted;

  assign add_b = acc[0] ? mcand : '0;

  CLA16bit u_cla (
    .A    (acc[2*WIDTH-1:WIDTH]),
    .B    (add_b),
    .Cin  (1'b0),
    .Sum  (sum),
    .Cout (cout)
  );

  // Adder carry enters at the top as the accumulator shifts right by one.
  assign acc_shifted = {1'b0, cout, sum, acc[WIDTH-1:1]};

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      cnt    <= '0;
      prod_r <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            acc   <= {{(WIDTH+1){1'b0}}, b};
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_shifted;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) prod_r <= acc_shifted[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = prod_r;
endmodule

// File: doc/mult16_seq.md
# mult16_seq

Sequential unsigned 16x16 shift-and-add multiplier built around the team's 16-bit carry-lookahead adder (`CLA16bit`). It is the downstream consumer of that adder: it feeds the adder one partial-product addition per clock and registers the adder's `Sum`/`Cout` back into an accumulator. A full 32-bit product is produced after 16 iterations. Handshake is `start`/`busy`/`done`.

## Interface
- `WIDTH`, default 16: operand width. Only 16 is supported because the adder instance is fixed at 16 bits.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a multiplication; sampled only in IDLE.
- `a` input 16: multiplicand, unsigned; captured on the accepting edge.
- `b` input 16: multiplier, unsigned; captured on the accepting edge.
- `busy` output 1: high while in RUN.
- `done` output 1: one-cycle pulse in DONE; `product` is valid from this cycle on.
- `product` output 32: last completed result; holds until the next DONE.

## Operation
- Internal registers:
  - `mcand[15:0]`
  - `acc[32:0]`: carry bit, high half, low half.
  - `cnt[3:0]`
  - `state`: IDLE, RUN or DONE.
  - `prod_r[31:0]`, which drives `product`.
- Adder datapath:
  - One `CLA16bit` instance with `A = acc[31:16]` and `B = acc[0] ? mcand : 16'h0000`.
  - `Cin = 0`.
- IDLE:
  - `start=1` loads `mcand <= a`, `acc <= {17'b0, b}` and `cnt <= 0`, then moves to RUN.
  - `start=0` stays in IDLE.
- RUN (one iteration per cycle):
  - `acc <= {Cout, Sum, acc[15:0]} >> 1`, a logical shift that brings the carry in at the top.
  - `cnt <= cnt + 1`.
  - If `cnt == 15`, the iteration completes, `prod_r` is loaded with the shifted `acc[31:0]`, and the block moves to DONE.
- DONE:
  - `done=1` for exactly one cycle, then unconditional move to IDLE.
- `start` in RUN or DONE is ignored. It is not queued.
- `a` and `b` are don't-care except on the accepting edge. Later changes must not affect the result.
- Arithmetic is unsigned. The product is exact for all operand pairs (max `0xFFFE0001`), and `acc[32]` is always 0 after the final shift.
- Operand zero gets no early termination: it always runs 16 iterations.

## Timing
- Reset (edge with `rst=1`):
  - state=IDLE, `busy=0`, `done=0`, `product=32'h0`.
  - `acc`, `mcand` and `cnt` are cleared.
- `rst` overrides `start` on the same edge.
- Reset mid-RUN or in DONE aborts the operation, clears `product` to 0, and produces no `done` pulse.
- Outputs are registered/decoded from state only, with no combinational path from `start`:
  - `busy = (state==RUN)`
  - `done = (state==DONE)`
- Latency, with E0 as the accepting edge:
  - `busy` is high for the 16 cycles after edges E0..E15.
  - Iterations complete on edges E1..E16.
  - `done=1` and the new `product` are visible in the cycle after E16.
  - The state is back in IDLE after E17.
  - Start-to-done is 17 cycles.
- Back-to-back: with `start` held high continuously, the next accept happens at E18. Throughput is one result per 18 cycles.
- `product` changes only on the edge entering DONE, or on reset. It is stable throughout RUN and shows the previous result.

## Test plan
- Reset then idle: `rst=1` for 2 cycles, then `start=0` for 5 cycles -> `product=0`, `busy=0`, `done=0` throughout.
- Max operands: `a=16'hFFFF`, `b=16'hFFFF`, one-cycle `start` -> `busy` high for 16 cycles, then `done` for exactly 1 cycle 17 cycles after accept, with `product=32'hFFFE0001` held afterwards.
- Decimal and zero cases, each from a fresh start:
  - `a=1234`, `b=5678` -> `product=32'h006AE9BC` (7006652).
  - `a=0`, `b=16'hBEEF` -> `product=0`, still 17-cycle latency.
  - `a=1`, `b=16'h8000` -> `32'h00008000`.
- Start while busy: accept `a=3`, `b=5`, then pulse `start` with `a=7`, `b=7` at cycle 8 -> `product=15`, a single `done` pulse, and no second operation.
- Reset mid-run: accept `a=16'h00FF`, `b=16'h0100`, assert `rst` at cycle 9 -> no `done`, `product=0`. A following accept of `a=2`, `b=3` yields `product=6` after 17 cycles.
- Back-to-back with held `start`: sequence of operands `(16'h0010, 16'h0010)` then `(16'h0002, 16'h8000)` -> `done` pulses 18 cycles apart with products `32'h00000100` then `32'h00010000`, and `product` stable between pulses.
